// File: rtl/instrn_prefix_decoder_pkg.sv
// Shared CPU decode types: opcode encoding, raw instruction layout and the
// default-width decoded instruction record.
package instrn_prefix_decoder_pkg;

    localparam int NIBBLE_WIDTH    = 4;
    localparam int CPU_WORD_WIDTH  = 8;
    localparam int CPU_COUNT_WIDTH = $clog2(CPU_WORD_WIDTH / NIBBLE_WIDTH + 1);

    typedef enum logic [3:0] {
        LDAM = 4'h0,
        LDBM = 4'h1,
        STAM = 4'h2,
        LDAC = 4'h3,
        LDBC = 4'h4,
        LDAP = 4'h5,
        LDAI = 4'h6,
        LDBI = 4'h7,
        STAI = 4'h8,
        BR   = 4'h9,
        BRZ  = 4'hA,
        BRN  = 4'hB,
        BRB  = 4'hC,
        ADD  = 4'hD,
        SUB  = 4'hE,
        PFIX = 4'hF
    } opcode_t;

    typedef struct packed {
        opcode_t                 opcode;
        logic [NIBBLE_WIDTH-1:0] operand;
    } instruction_t;

    typedef struct packed {
        opcode_t                    opcode;
        logic [CPU_WORD_WIDTH-1:0]  operand;
        logic [CPU_COUNT_WIDTH-1:0] count;
        logic                       overflow;
    } decoded_instrn_t;

endpackage

// File: rtl/instrn_prefix_decoder_sign_extender.sv
// Sign-extends a value from the top bit of its lowest i_nibbles nibbles.
// Nibble counts of zero or the full width pass the value through unchanged.
module operand_sign_extender
    import instrn_prefix_decoder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NIB_W = 2
) (
    input  logic [WIDTH-1:0] i_value,
    input  logic [NIB_W-1:0] i_nibbles,
    output logic [WIDTH-1:0] o_value
);

    always_comb begin
        o_value = i_value;
        for (int n = 1; n < WIDTH / NIBBLE_WIDTH; n++) begin
            if (i_nibbles == NIB_W'(n)) begin
                for (int b = NIBBLE_WIDTH * n; b < WIDTH; b++) begin
                    o_value[b] = i_value[NIBBLE_WIDTH*n-1];
                end
            end
        end
    end

endmodule

// File: rtl/instrn_prefix_decoder.sv
// Prefix-folding instruction decoder: PFIX nibbles accumulate into a wide
// operand that is emitted, one cycle later, with the next non-PFIX opcode.
module instrn_prefix_decoder
    import instrn_prefix_decoder_pkg::*;
#(
    parameter int WORD_WIDTH  = 8,
    parameter int SIGN_EXTEND = 0,
    parameter int MAX_PREFIX  = WORD_WIDTH / NIBBLE_WIDTH - 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              instrn_valid,
    output logic                              instrn_ready,
    input  logic [7:0]                        instrn,
    input  logic                              flush,
    output logic                              decoded_valid,
    input  logic                              decoded_ready,
    output logic [3:0]                        decoded_opcode,
    output logic [WORD_WIDTH-1:0]             decoded_operand,
    output logic [$clog2(MAX_PREFIX+2)-1:0]   decoded_prefix_count,
    output logic                              decoded_overflow
);

    localparam int CNT_W = $clog2(MAX_PREFIX + 2);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_PREFIX);
    localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(MAX_PREFIX + 1);

    typedef struct packed {
        opcode_t               opcode;
        logic [WORD_WIDTH-1:0] operand;
        logic [CNT_W-1:0]      count;
        logic                  overflow;
    } decoded_t;

    logic [WORD_WIDTH-1:0] r_oreg;
    logic [CNT_W-1:0]      r_count;
    logic                  r_ovf;
    logic                  r_valid;
    decoded_t              r_out;

    instruction_t          w_instrn;
    logic                  w_accept;
    logic                  w_is_pfix;
    logic [WORD_WIDTH-1:0] w_value;
    logic [WORD_WIDTH-1:0] w_extended;
    logic [WORD_WIDTH-1:0] w_operand;
    logic                  w_ext_en;

    assign w_instrn     = instruction_t'(instrn);
    assign instrn_ready = !r_valid || decoded_ready;
    assign w_accept     = instrn_valid && instrn_ready;
    assign w_is_pfix    = (w_instrn.opcode == PFIX);
    assign w_value      = r_oreg | WORD_WIDTH'(w_instrn.operand);

    // Extension only applies while every accumulated nibble is still intact
    // and the operand does not already fill the word.
    assign w_ext_en = !r_ovf && (r_count < CNT_LIMIT);

    generate
        if (SIGN_EXTEND != 0) begin : g_sext
            operand_sign_extender #(
                .WIDTH (WORD_WIDTH),
                .NIB_W (CNT_W)
            ) u_sext (
                .i_value   (w_value),
                .i_nibbles (r_count + CNT_W'(1)),
                .o_value   (w_extended)
            );
            assign w_operand = w_ext_en ? w_extended : w_value;
        end else begin : g_no_sext
            assign w_extended = w_value;
            assign w_operand  = w_value;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_oreg  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_valid <= 1'b0;
            r_out   <= '0;
        end else if (flush) begin
            r_oreg  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_valid <= 1'b0;
        end else if (w_accept && w_is_pfix) begin
            r_oreg <= w_value << NIBBLE_WIDTH;
            if (r_count == CNT_LIMIT) begin
                r_ovf <= 1'b1;
            end
            if (r_count != CNT_SAT) begin
                r_count <= r_count + CNT_W'(1);
            end
            if (decoded_ready) begin
                r_valid <= 1'b0;
            end
        end else if (w_accept) begin
            r_out.opcode   <= w_instrn.opcode;
            r_out.operand  <= w_operand;
            r_out.count    <= r_count;
            r_out.overflow <= r_ovf;
            r_valid        <= 1'b1;
            r_oreg         <= '0;
            r_count        <= '0;
            r_ovf          <= 1'b0;
        end else if (decoded_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign decoded_valid        = r_valid;
    assign decoded_opcode       = r_out.opcode;
    assign decoded_operand      = r_out.operand;
    assign decoded_prefix_count = r_out.count;
    assign decoded_overflow     = r_out.overflow;

endmodule

// File: tb/tb_instrn_prefix_decoder.sv
// Bench for instrn_prefix_decoder: two 8-bit instances (plain and
// sign-extending) share stimulus; a scoreboard checks every emitted output.
module tb_instrn_prefix_decoder;

    logic       clk;
    logic       rst;
    logic       instrn_valid;
    logic [7:0] instrn;
    logic       flush;
    logic       decoded_ready;

    logic       rdy0, rdy1, dv0, dv1, ov0, ov1;
    logic [3:0] op0, op1;
    logic [7:0] val0, val1;
    logic [1:0] cnt0, cnt1;

    typedef struct {
        logic [3:0] op;
        logic [7:0] v0;
        logic [7:0] v1;
        logic [1:0] cnt;
        logic       ovf;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cycle = 0;
    int   last_pop = -10;
    int   prev_pop = -10;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycle <= cycle + 1;

    instrn_prefix_decoder #(.WORD_WIDTH(8), .SIGN_EXTEND(0)) u_dut0 (
        .clk                  (clk),
        .rst                  (rst),
        .instrn_valid         (instrn_valid),
        .instrn_ready         (rdy0),
        .instrn               (instrn),
        .flush                (flush),
        .decoded_valid        (dv0),
        .decoded_ready        (decoded_ready),
        .decoded_opcode       (op0),
        .decoded_operand      (val0),
        .decoded_prefix_count (cnt0),
        .decoded_overflow     (ov0)
    );

    instrn_prefix_decoder #(.WORD_WIDTH(8), .SIGN_EXTEND(1)) u_dut1 (
        .clk                  (clk),
        .rst                  (rst),
        .instrn_valid         (instrn_valid),
        .instrn_ready         (rdy1),
        .instrn               (instrn),
        .flush                (flush),
        .decoded_valid        (dv1),
        .decoded_ready        (decoded_ready),
        .decoded_opcode       (op1),
        .decoded_operand      (val1),
        .decoded_prefix_count (cnt1),
        .decoded_overflow     (ov1)
    );

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && dv0 === 1'b1 && decoded_ready === 1'b1) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_output got op=%h operand=%h, required no output", op0, val0);
                end else begin
                    e = q.pop_front();
                    prev_pop = last_pop;
                    last_pop = cycle;
                    total++;
                    if (op0 !== e.op || op1 !== e.op) begin
                        bad++;
                        $display("FAIL opcode got %h/%h required %h", op0, op1, e.op);
                    end
                    total++;
                    if (val0 !== e.v0) begin
                        bad++;
                        $display("FAIL operand_plain got %h required %h", val0, e.v0);
                    end
                    total++;
                    if (val1 !== e.v1) begin
                        bad++;
                        $display("FAIL operand_sext got %h required %h", val1, e.v1);
                    end
                    total++;
                    if (cnt0 !== e.cnt || cnt1 !== e.cnt) begin
                        bad++;
                        $display("FAIL prefix_count got %0d/%0d required %0d", cnt0, cnt1, e.cnt);
                    end
                    total++;
                    if (ov0 !== e.ovf || ov1 !== e.ovf) begin
                        bad++;
                        $display("FAIL overflow got %b/%b required %b", ov0, ov1, e.ovf);
                    end
                    total++;
                    if (dv1 !== 1'b1) begin
                        bad++;
                        $display("FAIL valid_sext got %b required 1", dv1);
                    end
                end
            end
        end
    endtask

    task automatic expect_out(input logic [3:0] op, input logic [7:0] v0, input logic [7:0] v1,
                              input logic [1:0] c, input logic o);
        exp_t e;
        e.op = op; e.v0 = v0; e.v1 = v1; e.cnt = c; e.ovf = o;
        q.push_back(e);
    endtask

    task automatic send(input logic [7:0] ins);
        int guard;
        guard = 0;
        instrn = ins;
        instrn_valid = 1'b1;
        while (rdy0 !== 1'b1 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        total++;
        if (rdy0 !== 1'b1) begin
            bad++;
            $display("FAIL send_timeout instr=%h ready=%b required 1", ins, rdy0);
        end
        @(posedge clk); #1;
        instrn_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (q.size() != 0 && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d required 0", q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        instrn_valid = 1'b0;
        instrn = 8'h00;
        flush = 1'b0;
        decoded_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({dv0, op0, val0, cnt0, ov0} !== 16'h0 || {dv1, op1, val1, cnt1, ov1} !== 16'h0) begin
            bad++;
            $display("FAIL reset_outputs got %h/%h required 0", {dv0, op0, val0, cnt0, ov0}, {dv1, op1, val1, cnt1, ov1});
        end
        total++;
        if (rdy0 !== 1'b1 || rdy1 !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready got %b/%b required 1", rdy0, rdy1);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_prefix();
        send(8'hF3);
        total++;
        if (dv0 !== 1'b0) begin
            bad++;
            $display("FAIL pfix_no_output got valid=%b required 0", dv0);
        end
        expect_out(4'hD, 8'h35, 8'h35, 2'd1, 1'b0);
        send(8'hD5);
        drain();
    endtask

    task automatic test_latency();
        expect_out(4'h3, 8'h07, 8'h07, 2'd0, 1'b0);
        send(8'h37);
        total++;
        if (dv0 !== 1'b1 || op0 !== 4'h3) begin
            bad++;
            $display("FAIL latency got valid=%b op=%h required 1/3", dv0, op0);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        expect_out(4'h3, 8'h07, 8'h07, 2'd0, 1'b0);
        send(8'h37);
        expect_out(4'h4, 8'h05, 8'h05, 2'd0, 1'b0);
        send(8'h45);
        drain();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (last_pop - prev_pop !== 1) begin
            bad++;
            $display("FAIL back_to_back gap got %0d cycles required 1", last_pop - prev_pop);
        end
    endtask

    task automatic test_sign_extend();
        expect_out(4'h9, 8'h0A, 8'hFA, 2'd0, 1'b0);
        send(8'h9A);
        expect_out(4'h9, 8'h0A, 8'h0A, 2'd1, 1'b0);
        send(8'hF0);
        send(8'h9A);
        expect_out(4'h9, 8'hFF, 8'hFF, 2'd1, 1'b0);
        send(8'hFF);
        send(8'h9F);
        expect_out(4'hE, 8'h0C, 8'hFC, 2'd0, 1'b0);
        send(8'hEC);
        drain();
    endtask

    task automatic test_overflow();
        send(8'hF1);
        send(8'hF2);
        send(8'hF3);
        expect_out(4'hD, 8'h34, 8'h34, 2'd2, 1'b1);
        send(8'hD4);
        expect_out(4'hD, 8'h01, 8'h01, 2'd0, 1'b0);
        send(8'hD1);
        drain();
    endtask

    task automatic test_backpressure();
        decoded_ready = 1'b0;
        expect_out(4'h3, 8'h01, 8'h01, 2'd0, 1'b0);
        send(8'h31);
        expect_out(4'h4, 8'h02, 8'h02, 2'd0, 1'b0);
        instrn = 8'h42;
        instrn_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            total++;
            if (rdy0 !== 1'b0 || rdy1 !== 1'b0) begin
                bad++;
                $display("FAIL bp_ready got %b/%b required 0", rdy0, rdy1);
            end
            total++;
            if (dv0 !== 1'b1 || op0 !== 4'h3 || val0 !== 8'h01) begin
                bad++;
                $display("FAIL bp_hold got v=%b op=%h operand=%h required 1/3/01", dv0, op0, val0);
            end
        end
        decoded_ready = 1'b1;
        @(posedge clk); #1;
        instrn_valid = 1'b0;
        total++;
        if (dv0 !== 1'b1 || op0 !== 4'h4 || val0 !== 8'h02) begin
            bad++;
            $display("FAIL bp_release got v=%b op=%h operand=%h required 1/4/02", dv0, op0, val0);
        end
        drain();
    endtask

    task automatic test_flush();
        send(8'hF3);
        instrn = 8'hD5;
        instrn_valid = 1'b1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        instrn_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            total++;
            if (dv0 !== 1'b0 || dv1 !== 1'b0) begin
                bad++;
                $display("FAIL flush_drop got valid=%b/%b required 0", dv0, dv1);
            end
            @(posedge clk); #1;
        end
        expect_out(4'hD, 8'h05, 8'h05, 2'd0, 1'b0);
        send(8'hD5);
        drain();
    endtask

    task automatic test_reset_mid_prefix();
        send(8'hF3);
        instrn = 8'hD5;
        instrn_valid = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({dv0, op0, val0, cnt0, ov0} !== 16'h0 || {dv1, op1, val1, cnt1, ov1} !== 16'h0) begin
            bad++;
            $display("FAIL reset_mid_outputs got %h/%h required 0", {dv0, op0, val0, cnt0, ov0}, {dv1, op1, val1, cnt1, ov1});
        end
        rst = 1'b0;
        instrn_valid = 1'b0;
        @(posedge clk); #1;
        total++;
        if (dv0 !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_drop got valid=%b required 0", dv0);
        end
        expect_out(4'hD, 8'h05, 8'h05, 2'd0, 1'b0);
        send(8'hD5);
        drain();
    endtask

    initial begin
        rst = 1'b1;
        instrn_valid = 1'b0;
        instrn = 8'h00;
        flush = 1'b0;
        decoded_ready = 1'b1;
        fork
            monitor();
        join_none
        test_reset();
        test_prefix();
        test_latency();
        test_back_to_back();
        test_sign_extend();
        test_overflow();
        test_backpressure();
        test_flush();
        test_reset_mid_prefix();
        repeat (3) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
